// File: rtl/lpc_uart_framer_pkg.sv
// Shared definitions for the LPC-to-UART framer: FSM state encoding, record
// layout, frame geometry and a helper that selects one byte of a frame.
package lpc_uart_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_STROBE,
    ST_WAIT_BUSY,
    ST_WAIT_READY
  } fsm_state_t;

  localparam int unsigned FRAME_BYTES = 8;
  localparam int unsigned REC_W       = 44;

  // Packed record layout: {cyctype_dir[3:0], addr[31:0], data[7:0]}
  localparam int unsigned REC_DATA_LSB = 0;
  localparam int unsigned REC_ADDR_LSB = 8;
  localparam int unsigned REC_CTD_LSB  = 40;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  // Byte idx of the frame built from rec; byte 7 is the XOR of bytes 1..6.
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec,
                                            input logic             ovf,
                                            input logic [2:0]       idx,
                                            input logic [7:0]       sync);
    logic [7:0]  b1;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [7:0]  res;
    b1   = {ovf, 3'b000, rec[REC_CTD_LSB +: 4]};
    addr = rec[REC_ADDR_LSB +: 32];
    data = rec[REC_DATA_LSB +: 8];
    res  = '0;
    case (idx)
      3'd0: res = sync;
      3'd1: res = b1;
      3'd2: res = addr[31:24];
      3'd3: res = addr[23:16];
      3'd4: res = addr[15:8];
      3'd5: res = addr[7:0];
      3'd6: res = data;
      3'd7: res = b1 ^ addr[31:24] ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ data;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lpc_uart_framer_sync_fifo.sv
// Single-clock FIFO with show-ahead read port.
// Ports: clock/reset (sync, active-high); push/wdata write side; pop/rdata
// read side (rdata is the current head); full, empty, level status.
// A push while full is accepted when a pop happens in the same cycle.
module lpc_uart_framer_sync_fifo #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = AW + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push, do_pop;

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: it is only read behind a valid level.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lpc_uart_framer.sv
// Buffers decoded LPC transaction records and serialises each into an 8-byte
// frame for the UART transmitter (ready/latch handshake).
// Ports: clock, reset (sync, active-high); in_valid/in_cyctype_dir/in_addr/
// in_data record input; uart_ready (async, synchronised internally);
// uart_data/uart_latch to the transmitter; fifo_level, overflow (sticky until
// reported in a frame) and drop_count (saturating) status.
module lpc_uart_framer
  import lpc_uart_framer_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [3:0]               in_cyctype_dir,
  input  logic [31:0]              in_addr,
  input  logic [7:0]               in_data,
  input  logic                     uart_ready,
  output logic [7:0]               uart_data,
  output logic                     uart_latch,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  fsm_state_t       state_q, state_d;
  logic             sync1_q, rdy_q;
  logic [REC_W-1:0] frame_rec_q, frame_rec_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       uart_data_q, uart_data_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic [REC_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop, drop;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign drop     = in_valid && fifo_full && !fifo_pop;

  lpc_uart_framer_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .wdata ({in_cyctype_dir, in_addr, in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    frame_rec_d  = frame_rec_q;
    frame_ovf_d  = frame_ovf_q;
    idx_d        = idx_q;
    uart_data_d  = uart_data_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          frame_rec_d = fifo_rdata;
          frame_ovf_d = overflow_q;
          idx_d       = '0;
          // Load byte 0 now so data is stable for the whole PRESENT state.
          uart_data_d = frame_byte(fifo_rdata, overflow_q, 3'd0, SYNC_BYTE);
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT:   if (rdy_q) state_d = ST_STROBE;
      ST_STROBE:    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!rdy_q) state_d = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (rdy_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d       = idx_q + 3'd1;
            uart_data_d = frame_byte(frame_rec_q, frame_ovf_q, idx_q + 3'd1, SYNC_BYTE);
            state_d     = ST_PRESENT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop in the pop cycle wins, so it is reported in the following frame.
    if (fifo_pop) overflow_d = 1'b0;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      rdy_q        <= 1'b0;
      frame_rec_q  <= '0;
      frame_ovf_q  <= 1'b0;
      idx_q        <= '0;
      uart_data_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= uart_ready;
      rdy_q        <= sync1_q;
      frame_rec_q  <= frame_rec_d;
      frame_ovf_q  <= frame_ovf_d;
      idx_q        <= idx_d;
      uart_data_q  <= uart_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign uart_data  = uart_data_q;
  assign uart_latch = (state_q == ST_STROBE);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_lpc_uart_framer.sv
module tb_lpc_uart_framer;
  import lpc_uart_framer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        uart_ready;
  logic [7:0]  uart_data;
  logic        uart_latch;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;

  logic stall, force_hi, model_rdy;
  assign uart_ready = force_hi ? 1'b1 : (stall ? 1'b0 : model_rdy);

  int total = 0;
  int bad = 0;
  int latch_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  lpc_uart_framer #(.DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
    .uart_ready(uart_ready), .uart_data(uart_data), .uart_latch(uart_latch),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent frame builder from the frame format description.
  task automatic push_frame(input logic [3:0] ct, input logic [31:0] a,
                            input logic [7:0] d, input logic ovf);
    logic [7:0] b1;
    b1 = {ovf, 3'b000, ct};
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(a[31:24]);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d);
    exp_q.push_back(b1 ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ d);
  endtask

  task automatic send(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
    @(negedge clock);
    in_valid = 1'b1; in_cyctype_dir = ct; in_addr = a; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (40) @(negedge clock);
  endtask

  // Monitor: every latch pulse consumes one expected byte.
  initial begin
    forever begin
      @(negedge clock);
      if (uart_latch === 1'b1) begin
        latch_cnt++;
        if (exp_q.size() == 0) check("unexpected_latch", {24'h0, uart_data}, 32'h1ff);
        else check("frame_byte", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Transmitter model: ready drops 3 clocks after a latch, returns 20 later.
  initial begin
    model_rdy = 1'b1;
    forever begin
      @(negedge clock);
      if (uart_latch === 1'b1 && !stall) begin
        repeat (3) @(negedge clock);
        model_rdy = 1'b0;
        repeat (20) @(negedge clock);
        model_rdy = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    logic [7:0] hold;
    logic changed;

    reset = 1'b1; in_valid = 1'b0; in_cyctype_dir = '0; in_addr = '0; in_data = '0;
    stall = 1'b0; force_hi = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data", uart_data, 0);
    check("rst_latch", uart_latch, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drops", drop_count, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Single record, hand-computed frame
    foreach (exp_q[i]) ;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h02); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hBE);
    base = latch_cnt;
    send(4'h2, 32'h0000_0080, 8'h3C);
    wait_drain(2000);
    check("single_latches", latch_cnt - base, 8);
    check("single_level", fifo_level, 0);

    // Stalled transmitter: blocker frame sits in PRESENT, then a 10-record burst
    stall = 1'b1;
    repeat (4) @(negedge clock);
    push_frame(4'h1, 32'hB10C_0000, 8'h00, 1'b0);
    send(4'h1, 32'hB10C_0000, 8'h00);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_cyctype_dir = 4'(i);
      in_addr = 32'h1000_0000 + 32'(i * 16);
      in_data = 8'(8'h10 + i);
      if (i < 8) push_frame(4'(i), 32'h1000_0000 + 32'(i * 16), 8'(8'h10 + i), i == 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("burst_level", fifo_level, 8);
    check("burst_drops", drop_count, 2);
    check("burst_ovf", overflow, 1);

    // Release; push in the same cycle as the pop of a full FIFO
    stall = 1'b0;
    n = 0;
    while (!(dut.state_q == ST_IDLE && fifo_level == 4'd8) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) check("pop_wait_timeout", n, 0);
    in_valid = 1'b1; in_cyctype_dir = 4'hC; in_addr = 32'hCAFE_F00D; in_data = 8'h77;
    push_frame(4'hC, 32'hCAFE_F00D, 8'h77, 1'b0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("pushpop_level", fifo_level, 8);
    check("pushpop_drops", drop_count, 2);
    check("pushpop_ovf_clr", overflow, 0);
    wait_drain(6000);
    check("burst_final_level", fifo_level, 0);
    check("burst_final_ovf", overflow, 0);

    // Ready held high after a latch: no second latch, data stable
    push_frame(4'h5, 32'h1234_5678, 8'h9A, 1'b0);
    force_hi = 1'b1;
    send(4'h5, 32'h1234_5678, 8'h9A);
    n = 0;
    while (uart_latch !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("hold_latch_timeout", n, 0);
    @(negedge clock);
    base = latch_cnt;
    hold = uart_data;
    changed = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (uart_data !== hold) changed = 1'b1;
    end
    check("hold_no_latch", latch_cnt - base, 0);
    check("hold_data_stable", changed, 0);
    force_hi = 1'b0;
    stall = 1'b1;
    repeat (6) @(negedge clock);
    stall = 1'b0;
    wait_drain(3000);

    // Reset while byte 4 is in WAIT_BUSY
    push_frame(4'h3, 32'hA0B0_C0D0, 8'hE1, 1'b0);
    base = latch_cnt;
    send(4'h3, 32'hA0B0_C0D0, 8'hE1);
    n = 0;
    while (latch_cnt - base < 5 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) check("b4_timeout", n, 0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    check("midrst_latch", uart_latch, 0);
    check("midrst_data", uart_data, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_drops", drop_count, 0);
    check("midrst_ovf", overflow, 0);
    @(negedge clock);
    reset = 1'b0;
    base = latch_cnt;
    repeat (100) @(negedge clock);
    check("midrst_no_latch", latch_cnt - base, 0);

    // drop_count saturation with 300 dropped records
    stall = 1'b1;
    repeat (4) @(negedge clock);
    send(4'h7, 32'h0, 8'h00);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 308; i++) begin
      in_valid = 1'b1;
      in_addr = 32'(i);
      in_data = 8'(i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("sat_drops", drop_count, 255);
    check("sat_level", fifo_level, 8);
    check("sat_ovf", overflow, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    check("sat_rst_drops", drop_count, 0);
    repeat (10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
